// File: rtl/result_to_ascii_pkg.sv
// result_to_ascii_pkg: shared states, ASCII constants and result width
package result_to_ascii_pkg;
  localparam int RES_W = 5;
  localparam logic [7:0] ASCII_PLUS = 8'd43;
  localparam logic [7:0] ASCII_MINUS = 8'd45;
  localparam logic [7:0] ASCII_ZERO = 8'd48;
  localparam logic [7:0] ASCII_NL = 8'd10;
  typedef enum logic [2:0] {
    IDLE,
    CONVERT,
    SEND_SIGN,
    SEND_TENS,
    SEND_ONES,
    SEND_TERM
  } state_t;
endpackage

// File: rtl/result_to_ascii_dabble_step.sv
// dabble_step: one double-dabble iteration (add-3 correction, then shift) on {tens,ones,mag}
module dabble_step (
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  input  logic [5:0] mag,
  output logic [3:0] tens_n,
  output logic [3:0] ones_n,
  output logic [5:0] mag_n
);
  logic [3:0] t, o;
  assign t = tens >= 4'd5 ? tens + 4'd3 : tens;
  assign o = ones >= 4'd5 ? ones + 4'd3 : ones;
  assign {tens_n, ones_n, mag_n} = {t[2:0], o, mag, 1'b0};
endmodule

// File: rtl/result_to_ascii.sv
// result_to_ascii: turns a 5-bit adder result into a 4-character signed decimal record
module result_to_ascii
  import result_to_ascii_pkg::*;
#(
  parameter logic [7:0] SIGN_POS = ASCII_PLUS,
  parameter logic [7:0] TERM_CHAR = ASCII_NL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [RES_W-1:0] s,
  input  logic             c5,
  input  logic             e,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data
);
  state_t state, nxt;
  logic [2:0] cnt;
  logic [5:0] val, v_in, abs_v, mag, mag_n;
  logic [3:0] tens, ones, tens_n, ones_n;
  logic neg, send;
  logic [7:0] ch;
  // on overflow the carry-out is the true sign bit
  assign v_in = e ? {c5, s} : {s[RES_W-1], s};
  assign abs_v = val[5] ? -val : val;
  assign send = state == SEND_SIGN || state == SEND_TENS || state == SEND_ONES || state == SEND_TERM;
  assign in_ready = rst || state == IDLE;
  assign out_valid = !rst && send;
  assign out_data = rst ? 8'd0 : ch;
  dabble_step u_step (
    .tens  (tens),
    .ones  (ones),
    .mag   (mag),
    .tens_n(tens_n),
    .ones_n(ones_n),
    .mag_n (mag_n)
  );
  always_comb begin
    nxt = state;
    case (state)
      IDLE:      nxt = in_valid ? CONVERT : IDLE;
      CONVERT:   nxt = cnt == 3'd6 ? SEND_SIGN : CONVERT;
      SEND_SIGN: nxt = out_ready ? SEND_TENS : SEND_SIGN;
      SEND_TENS: nxt = out_ready ? SEND_ONES : SEND_TENS;
      SEND_ONES: nxt = out_ready ? SEND_TERM : SEND_ONES;
      SEND_TERM: nxt = out_ready ? IDLE : SEND_TERM;
      default:   nxt = IDLE;
    endcase
  end
  always_comb begin
    ch = 8'd0;
    case (state)
      SEND_SIGN: ch = neg ? ASCII_MINUS : SIGN_POS;
      SEND_TENS: ch = ASCII_ZERO + {4'd0, tens};
      SEND_ONES: ch = ASCII_ZERO + {4'd0, ones};
      SEND_TERM: ch = TERM_CHAR;
      default:   ch = 8'd0;
    endcase
  end
  // first CONVERT cycle loads the magnitude, the next six shift it into BCD
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= 3'd0;
      val <= 6'd0;
      neg <= 1'b0;
      mag <= 6'd0;
      tens <= 4'd0;
      ones <= 4'd0;
    end else begin
      state <= nxt;
      if (state == IDLE && in_valid) begin
        val <= v_in;
        cnt <= 3'd0;
      end
      if (state == CONVERT) begin
        cnt <= cnt + 3'd1;
        if (cnt == 3'd0) begin
          neg <= val[5];
          mag <= abs_v;
          tens <= 4'd0;
          ones <= 4'd0;
        end else begin
          tens <= tens_n;
          ones <= ones_n;
          mag <= mag_n;
        end
      end
    end
  end
endmodule

// File: tb/tb_result_to_ascii.sv
// tb_result_to_ascii: directed checks of record content, timing, stalls, reset and back-to-back capture
module tb_result_to_ascii;
  logic clk = 0, rst = 1, in_valid = 0, in_ready, c5 = 0, e = 0, out_valid, out_ready = 1;
  logic [4:0] s = 0;
  logic [7:0] out_data;
  int nchk = 0, nerr = 0;

  result_to_ascii dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .s(s), .c5(c5), .e(e),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [4:0] sv, input logic c5v, input logic ev);
    s = sv; c5 = c5v; e = ev; in_valid = 1;
    step();
    in_valid = 0;
  endtask

  task automatic collect(input int want, output logic [31:0] rec, output int n, output int cyc);
    n = 0; rec = 0; cyc = 0;
    for (int i = 0; i < 40 && n < want; i++) begin
      if (out_valid && out_ready) begin
        rec = {rec[23:0], out_data};
        n++;
      end
      step();
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1; in_valid = 1; out_ready = 1;
    step(); step();
    nchk++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL rst_in_ready: got %b expected 1", in_ready); end
    nchk++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
    nchk++; if (out_data !== 8'd0) begin nerr++; $display("FAIL rst_out_data: got %0d expected 0", out_data); end
    in_valid = 0; rst = 0;
    step();
    nchk++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL post_rst_in_ready: got %b expected 1", in_ready); end
    nchk++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL post_rst_out_valid: got %b expected 0", out_valid); end
    nchk++; if (out_data !== 8'd0) begin nerr++; $display("FAIL post_rst_out_data: got %0d expected 0", out_data); end
  endtask

  task automatic test_latency();
    logic ev, er;
    send(5'b00011, 1'b0, 1'b0);
    for (int k = 1; k <= 11; k++) begin
      step();
      ev = k >= 7 && k <= 10;
      er = k >= 11;
      nchk++; if (out_valid !== ev) begin nerr++; $display("FAIL lat_out_valid k=%0d: got %b expected %b", k, out_valid, ev); end
      nchk++; if (in_ready !== er) begin nerr++; $display("FAIL lat_in_ready k=%0d: got %b expected %b", k, in_ready, er); end
      if (k == 7) begin
        nchk++; if (out_data !== 8'd43) begin nerr++; $display("FAIL lat_sign: got %0d expected 43", out_data); end
      end
    end
  endtask

  task automatic test_records();
    logic [4:0] tv_s [7] = '{5'b00011, 5'b11111, 5'b11110, 5'b00000, 5'b00000, 5'b10000, 5'b01111};
    logic tv_c [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic tv_e [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] tv_x [7] = '{"+03\n", "-01\n", "+30\n", "+00\n", "-32\n", "-16\n", "+15\n"};
    logic [31:0] rec;
    int n, cyc;
    for (int i = 0; i < 7; i++) begin
      send(tv_s[i], tv_c[i], tv_e[i]);
      collect(4, rec, n, cyc);
      nchk++; if (rec !== tv_x[i] || cyc != 11) begin nerr++; $display("FAIL record %0d: got %h in %0d cycles expected %h in 11", i, rec, cyc, tv_x[i]); end
    end
  endtask

  task automatic test_stall();
    logic [31:0] rec;
    int n, cyc;
    send(5'b00011, 1'b0, 1'b0);
    for (int i = 0; i < 20 && !out_valid; i++) step();
    nchk++; if (out_data !== 8'd43 || out_valid !== 1'b1) begin nerr++; $display("FAIL stall_sign: got %0d/%b expected 43/1", out_data, out_valid); end
    step();
    out_ready = 0;
    for (int k = 0; k < 4; k++) begin
      nchk++; if (out_valid !== 1'b1 || out_data !== 8'd48) begin nerr++; $display("FAIL stall_hold %0d: got %0d/%b expected 48/1", k, out_data, out_valid); end
      if (k < 3) step();
    end
    out_ready = 1;
    collect(3, rec, n, cyc);
    nchk++; if (rec !== {8'd0, "03\n"} || n != 3) begin nerr++; $display("FAIL stall_resume: got %h n=%0d expected %h n=3", rec, n, {8'd0, "03\n"}); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rec;
    int n, cyc;
    logic seen;
    send(5'b00011, 1'b0, 1'b0);
    for (int i = 0; i < 20 && !out_valid; i++) step();
    step(); step();
    nchk++; if (out_data !== 8'd51 || out_valid !== 1'b1) begin nerr++; $display("FAIL mid_ones: got %0d/%b expected 51/1", out_data, out_valid); end
    rst = 1;
    step();
    rst = 0;
    nchk++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL mid_rst_out_valid: got %b expected 0", out_valid); end
    nchk++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL mid_rst_in_ready: got %b expected 1", in_ready); end
    seen = 0;
    for (int k = 0; k < 4; k++) begin step(); seen |= out_valid; end
    nchk++; if (seen !== 1'b0) begin nerr++; $display("FAIL mid_rst_quiet: got %b expected 0", seen); end
    send(5'b11111, 1'b1, 1'b0);
    collect(4, rec, n, cyc);
    nchk++; if (rec !== "-01\n") begin nerr++; $display("FAIL mid_rst_next: got %h expected %h", rec, "-01\n"); end
  endtask

  task automatic test_back_to_back();
    logic [4:0] bs [3] = '{5'b00101, 5'b11011, 5'b01010};
    logic [31:0] bx [3] = '{"+05\n", "-05\n", "+10\n"};
    logic [31:0] rec;
    int n, cyc;
    in_valid = 1; c5 = 0; e = 0;
    for (int r = 0; r < 3; r++) begin
      s = bs[r];
      step();
      nchk++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL b2b_capture %0d: got in_ready %b expected 0", r, in_ready); end
      s = ~bs[r]; e = 1; c5 = 1;
      collect(4, rec, n, cyc);
      e = 0; c5 = 0;
      nchk++; if (rec !== bx[r] || cyc != 11) begin nerr++; $display("FAIL b2b_record %0d: got %h in %0d expected %h in 11", r, rec, cyc, bx[r]); end
      nchk++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL b2b_idle %0d: got %b expected 1", r, in_ready); end
    end
    in_valid = 0;
    step();
  endtask

  initial begin
    test_reset();
    test_latency();
    test_records();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end
endmodule
